// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: control codes, FSM states, datapath width.
package alu_pkg;

    localparam int ALU_W = 64;

    localparam logic [3:0] CTRL_AND   = 4'b0000;
    localparam logic [3:0] CTRL_OR    = 4'b0001;
    localparam logic [3:0] CTRL_ADD   = 4'b0010;
    localparam logic [3:0] CTRL_SUB   = 4'b0110;
    localparam logic [3:0] CTRL_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational N-bit ALU; unsupported control codes yield zero with err set.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic [3:0]   ctrl,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         err
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (ctrl)
            CTRL_AND:   result = a & b;
            CTRL_OR:    result = a | b;
            CTRL_ADD:   result = a + b;
            CTRL_SUB:   result = a - b;
            CTRL_PASSB: result = b;
            default:    err    = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sequencing one shared ALU, one operation in flight at a time.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 always wins ties.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int N = ALU_W
) (
    input  logic         CLK,
    input  logic         Reset_L,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_ctrl,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_ctrl,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_data,
    output logic         resp_zero,
    output logic         resp_err
);

    state_t       state, state_next;
    logic         grant1;
    logic         accept;
    logic [3:0]   op_ctrl;
    logic [N-1:0] op_a, op_b;
    logic         op_id;
    logic [N-1:0] alu_result;
    logic         alu_zero, alu_err;

`ifdef ALU_ARB_RR_EN
    // Remembers the last granted requester; reset to 1 so requester 0 wins the first tie.
    logic last_grant;

    always_ff @(posedge CLK) begin
        if (!Reset_L)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant1;
    end

    assign grant1 = req1_valid & (~req0_valid | ~last_grant);
`else
    assign grant1 = req1_valid & ~req0_valid;
`endif

    assign req0_ready = (state == ST_IDLE) & ~grant1 & req0_valid;
    assign req1_ready = (state == ST_IDLE) &  grant1 & req1_valid;
    assign accept     = req0_ready | req1_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (!Reset_L)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)     state_next = ST_EXEC;
            ST_EXEC:                 state_next = ST_RESP;
            ST_RESP: if (resp_ready) state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // NOTE: operand holding registers are not reset; they are always loaded before being read.
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_ctrl <= grant1 ? req1_ctrl : req0_ctrl;
            op_a    <= grant1 ? req1_a    : req0_a;
            op_b    <= grant1 ? req1_b    : req0_b;
            op_id   <= grant1;
        end
    end

    alu_core #(.N(N)) u_alu_core (
        .ctrl   (op_ctrl),
        .a      (op_a),
        .b      (op_b),
        .result (alu_result),
        .zero   (alu_zero),
        .err    (alu_err)
    );

    // Response registers load only in EXEC, so they stay stable through RESP.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            resp_id   <= 1'b0;
            resp_data <= '0;
            resp_zero <= 1'b0;
            resp_err  <= 1'b0;
        end else if (state == ST_EXEC) begin
            resp_id   <= op_id;
            resp_data <= alu_result;
            resp_zero <= alu_zero;
            resp_err  <= alu_err;
        end
    end

    assign resp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the ALU and the arbitration rule.
module tb_alu_share_arbiter;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [63:0] resp_data;

    int vectors     = 0;
    int miscompares = 0;
    bit model_last  = 1'b1;

    always #5 CLK = ~CLK;

    alu_share_arbiter dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err)
    );

    // Returns {err, result} from the control-code table.
    function automatic logic [64:0] ref_alu(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
        case (c)
            4'b0000: return {1'b0, a & b};
            4'b0001: return {1'b0, a | b};
            4'b0010: return {1'b0, a + b};
            4'b0110: return {1'b0, a - b};
            4'b0111: return {1'b0, b};
            default: return {1'b1, 64'd0};
        endcase
    endfunction

    function automatic bit ref_winner(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
            return ~model_last;
`else
            return 1'b0;
`endif
        end
        return v1;
    endfunction

    task automatic clear_reqs();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_reqs();
        Reset_L = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        Reset_L = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic accept_resp();
        resp_ready = 1'b1;
        @(posedge CLK); #1;
        resp_ready = 1'b0;
    endtask

    // Drives one request phase, waits (bounded) for a grant and the response, then consumes it.
    task automatic run_op(input bit v0, input bit v1,
                          input logic [3:0] c0, input logic [63:0] a0, input logic [63:0] b0,
                          input logic [3:0] c1, input logic [63:0] a1, input logic [63:0] b1,
                          input int resp_delay, output bit ok, output logic [1:0] rdy,
                          output bit id, output logic [63:0] d, output bit z, output bit e);
        int n;
        ok = 1'b0; rdy = 2'b00; id = 1'b0; d = '0; z = 1'b0; e = 1'b0;
        req0_valid = v0; req0_ctrl = c0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_ctrl = c1; req1_a = a1; req1_b = b1;
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 8) begin
            @(posedge CLK); #1; n++;
        end
        rdy = {req1_ready, req0_ready};
        if (rdy == 2'b00) begin
            clear_reqs();
            return;
        end
        @(posedge CLK); #1;
        clear_reqs();
        n = 0;
        while (!resp_valid && n < 8) begin
            @(posedge CLK); #1; n++;
        end
        if (!resp_valid) return;
        repeat (resp_delay) begin
            @(posedge CLK); #1;
        end
        id = resp_id; d = resp_data; z = resp_zero; e = resp_err;
        accept_resp();
        ok = 1'b1;
    endtask

    task automatic test_reset();
        clear_reqs();
        Reset_L = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        vectors++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_err} !== 6'b0 || resp_data !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_values got rdy0=%b rdy1=%b valid=%b id=%b data=%h zero=%b err=%b want all 0",
                     req0_ready, req1_ready, resp_valid, resp_id, resp_data, resp_zero, resp_err);
        end
        Reset_L = 1'b1;
        model_last = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle got resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_basic_add();
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 64'd5; req0_b = 64'd7;
        #1;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++; $display("FAIL add_ready got rdy0=%b rdy1=%b want 1 0", req0_ready, req1_ready);
        end
        @(posedge CLK); #1;
        clear_reqs();
        model_last = 1'b0;
        vectors++;
        if (resp_valid !== 1'b0 || req0_ready !== 1'b0) begin
            miscompares++; $display("FAIL add_exec got valid=%b rdy0=%b want 0 0", resp_valid, req0_ready);
        end
        @(posedge CLK); #1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 64'd12 || resp_zero !== 1'b0 || resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL add_resp got valid=%b id=%b data=%h zero=%b err=%b want 1 0 c 0 0",
                     resp_valid, resp_id, resp_data, resp_zero, resp_err);
        end
        accept_resp();
        vectors++;
        if (resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL add_done got resp_valid=%b want 0", resp_valid);
        end
    endtask

    task automatic test_sub();
        bit ok, id, z, e;
        logic [1:0] rdy;
        logic [63:0] d;
        run_op(1'b0, 1'b1, 4'd0, 64'd0, 64'd0, 4'b0110, 64'd9, 64'd9, 0, ok, rdy, id, d, z, e);
        model_last = 1'b1;
        vectors++;
        if (!ok || rdy !== 2'b10 || id !== 1'b1 || d !== 64'd0 || z !== 1'b1 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_equal got ok=%b rdy=%b id=%b data=%h zero=%b err=%b want 1 10 1 0 1 0", ok, rdy, id, d, z, e);
        end
        run_op(1'b0, 1'b1, 4'd0, 64'd0, 64'd0, 4'b0110, 64'd0, 64'd1, 0, ok, rdy, id, d, z, e);
        vectors++;
        if (!ok || id !== 1'b1 || d !== 64'hFFFF_FFFF_FFFF_FFFF || z !== 1'b0 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL sub_wrap got ok=%b id=%b data=%h zero=%b err=%b want 1 1 ffffffffffffffff 0 0", ok, id, d, z, e);
        end
    endtask

    task automatic test_invalid_ctrl();
        bit ok, id, z, e;
        logic [1:0] rdy;
        logic [63:0] d;
        run_op(1'b1, 1'b0, 4'b1111, 64'd3, 64'd4, 4'd0, 64'd0, 64'd0, 1, ok, rdy, id, d, z, e);
        model_last = 1'b0;
        vectors++;
        if (!ok || id !== 1'b0 || d !== 64'd0 || z !== 1'b1 || e !== 1'b1) begin
            miscompares++;
            $display("FAIL invalid_ctrl got ok=%b id=%b data=%h zero=%b err=%b want 1 0 0 1 1", ok, id, d, z, e);
        end
    endtask

    task automatic test_tie();
        bit ok, id, z, e;
        logic [1:0] rdy;
        logic [63:0] d;
        bit exp;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            exp = i[0];
`else
            exp = 1'b0;
`endif
            run_op(1'b1, 1'b1, 4'b0010, 64'd100, 64'(i), 4'b0001, 64'hF0, 64'(i), 0, ok, rdy, id, d, z, e);
            model_last = exp;
            vectors++;
            if (!ok || rdy !== (exp ? 2'b10 : 2'b01) || id !== exp) begin
                miscompares++;
                $display("FAIL tie_grant[%0d] got ok=%b rdy=%b id=%b want grant %0d", i, ok, rdy, id, exp);
            end
            vectors++;
            if (d !== (exp ? (64'hF0 | 64'(i)) : (64'd100 + 64'(i)))) begin
                miscompares++; $display("FAIL tie_data[%0d] got %h want winner's result", i, d);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [63:0] b0, a1, b1;
        b0 = {$urandom, $urandom}; a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        req0_valid = 1'b1; req0_ctrl = 4'b0111; req0_a = 64'd0; req0_b = b0;
        #1;
        @(posedge CLK); #1;
        clear_reqs();
        model_last = 1'b0;
        @(posedge CLK); #1;
        req1_valid = 1'b1; req1_ctrl = 4'b0000; req1_a = a1; req1_b = b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall[%0d] got valid=%b id=%b data=%h rdy0=%b rdy1=%b want 1 0 %h 0 0",
                         i, resp_valid, resp_id, resp_data, req0_ready, req1_ready, b0);
            end
            @(posedge CLK); #1;
        end
        accept_resp();
        vectors++;
        if (req1_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL stall_release got rdy1=%b valid=%b want 1 0", req1_ready, resp_valid);
        end
        @(posedge CLK); #1;
        clear_reqs();
        model_last = 1'b1;
        @(posedge CLK); #1;
        vectors++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b1 || resp_data !== (a1 & b1)) begin
            miscompares++;
            $display("FAIL stall_next got valid=%b id=%b data=%h want 1 1 %h", resp_valid, resp_id, resp_data, a1 & b1);
        end
        accept_resp();
    endtask

    task automatic test_reset_mid_exec();
        bit ok, id, z, e;
        logic [1:0] rdy;
        logic [63:0] d;
        req1_valid = 1'b1; req1_ctrl = 4'b0010; req1_a = 64'd40; req1_b = 64'd2;
        #1;
        @(posedge CLK); #1;
        clear_reqs();
        Reset_L = 1'b0;
        @(posedge CLK); #1;
        Reset_L = 1'b1;
        model_last = 1'b1;
        vectors++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_err} !== 6'b0 || resp_data !== 64'd0) begin
            miscompares++;
            $display("FAIL exec_reset got valid=%b id=%b data=%h zero=%b err=%b want all 0",
                     resp_valid, resp_id, resp_data, resp_zero, resp_err);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            vectors++;
            if (resp_valid !== 1'b0) begin
                miscompares++; $display("FAIL exec_reset_noresp[%0d] got resp_valid=%b want 0", i, resp_valid);
            end
        end
        run_op(1'b1, 1'b1, 4'b0001, 64'h3, 64'h5, 4'b0010, 64'd1, 64'd1, 0, ok, rdy, id, d, z, e);
        model_last = 1'b0;
        vectors++;
        if (!ok || rdy !== 2'b01 || id !== 1'b0 || d !== 64'h7) begin
            miscompares++; $display("FAIL exec_reset_tie got ok=%b rdy=%b id=%b data=%h want 1 01 0 7", ok, rdy, id, d);
        end
    endtask

    task automatic test_random();
        bit ok, id, z, e, v0, v1, exp;
        logic [1:0] rdy, pat;
        logic [63:0] d, a0, b0, a1, b1, ea, eb;
        logic [3:0] c0, c1, ec;
        logic [64:0] r;
        logic [3:0] codes [6];
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0000};
        for (int i = 0; i < 60; i++) begin
            pat = 2'($urandom_range(1, 3));
            v0 = pat[0]; v1 = pat[1];
            codes[5] = 4'($urandom);
            c0 = codes[$urandom_range(0, 5)]; c1 = codes[$urandom_range(0, 5)];
            a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
            a1 = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
            b1 = ($urandom_range(0, 7) == 0) ? a1 : {$urandom, $urandom};
            exp = ref_winner(v0, v1);
            ec = exp ? c1 : c0; ea = exp ? a1 : a0; eb = exp ? b1 : b0;
            r = ref_alu(ec, ea, eb);
            run_op(v0, v1, c0, a0, b0, c1, a1, b1, $urandom_range(0, 2), ok, rdy, id, d, z, e);
            model_last = exp;
            vectors++;
            if (!ok || rdy !== (exp ? 2'b10 : 2'b01) || id !== exp || d !== r[63:0] || z !== (r[63:0] == 64'd0) || e !== r[64]) begin
                miscompares++;
                $display("FAIL random[%0d] got ok=%b rdy=%b id=%b data=%h zero=%b err=%b want id=%b data=%h err=%b",
                         i, ok, rdy, id, d, z, e, exp, r[63:0], r[64]);
            end
        end
    endtask

    initial begin
        Reset_L = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_basic_add();
        test_sub();
        test_invalid_ctrl();
        test_tie();
        test_back_to_back_stall();
        test_reset_mid_exec();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors", vectors);
        $fatal(1, "watchdog");
    end

endmodule
